// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for a five-stage in-order pipeline.
// Arbitrates memory wait states, multi-cycle multiply/divide, taken
// branches and load-use hazards into register write enables and bubble
// controls, and keeps a saturating stall counter plus two sticky flags.
//
// Handshake note: mem_req/mem_ready act as a valid/ready pair on the data
// memory port. An access completes in the cycle where both are high;
// while mem_req is high and mem_ready is low the whole pipe is frozen.
module pipeline_stall_ctrl #(
  parameter int MDU_LAT     = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        mdu_start,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_write,
  output logic        ex_mem_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_mem_bubble,
  output logic        mem_wb_bubble,
  output logic        mdu_busy,
  output logic        mem_timeout,
  output logic        protocol_err,
  output logic [15:0] stall_cnt,
  output logic [1:0]  o_dbg_state
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MDU_WAIT = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  // The start cycle is itself a stall cycle, so the counter covers the rest.
  localparam logic [3:0] MCNT_INIT  = 4'(MDU_LAT - 1);
  localparam logic [7:0] TCNT_LIMIT = 8'(MEM_TIMEOUT);

  logic [1:0]  r_state;
  logic [3:0]  r_mcnt;
  logic [7:0]  r_tcnt;
  logic        r_mem_timeout;
  logic        r_protocol_err;
  logic [15:0] r_stall_cnt;

  logic [1:0]  w_next_state;
  logic [3:0]  w_mcnt_next;
  logic [7:0]  w_tcnt_next;
  logic        w_set_timeout;
  logic        w_set_perr;

  // Decode state and inputs into pipeline controls and next-state values.
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    mdu_busy      = 1'b0;
    w_next_state  = r_state;
    w_mcnt_next   = r_mcnt;
    w_tcnt_next   = r_tcnt;
    w_set_timeout = 1'b0;
    w_set_perr    = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_write  = 1'b0;
          mem_wb_bubble = 1'b1;
          w_tcnt_next   = 8'd1;
          w_next_state  = ST_MEM_WAIT;
        end else if (mdu_start) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          w_mcnt_next   = MCNT_INIT;
          w_next_state  = ST_MDU_WAIT;
          // A taken branch alongside an MDU op is a hazard-unit bug; flag it.
          w_set_perr    = branch_taken;
        end else if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
      ST_MDU_WAIT: begin
        mdu_busy = 1'b1;
        if (r_mcnt != 4'd0) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          w_mcnt_next   = r_mcnt - 4'd1;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_write  = 1'b0;
          mem_wb_bubble = 1'b1;
          w_tcnt_next   = (r_tcnt == 8'hFF) ? 8'hFF : r_tcnt + 8'd1;
          w_set_timeout = (r_tcnt == TCNT_LIMIT);
        end else begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    // Reset overrides everything so the pipe sees a clean, free-running state.
    if (!rst_n) begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      mem_wb_bubble = 1'b0;
      mdu_busy      = 1'b0;
    end
  end

  // State, counters, sticky flags and the saturating stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_mcnt         <= 4'd0;
      r_tcnt         <= 8'd0;
      r_mem_timeout  <= 1'b0;
      r_protocol_err <= 1'b0;
      r_stall_cnt    <= 16'd0;
    end else begin
      r_state <= w_next_state;
      r_mcnt  <= w_mcnt_next;
      r_tcnt  <= w_tcnt_next;
      if (w_set_timeout) r_mem_timeout <= 1'b1;
      if (w_set_perr) r_protocol_err <= 1'b1;
      if (!pc_write && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign mem_timeout  = r_mem_timeout;
  assign protocol_err = r_protocol_err;
  assign stall_cnt    = r_stall_cnt;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed testbench for pipeline_stall_ctrl with a cycle-level reference
// model and literal spot checks on the defining scenarios.
module tb_pipeline_stall_ctrl;

  localparam int MDU_LAT     = 4;
  localparam int MEM_TIMEOUT = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, load_use, branch_taken, mdu_start, mem_req, mem_ready;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
  logic mdu_busy, mem_timeout, protocol_err;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  pipeline_stall_ctrl #(.MDU_LAT(MDU_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
    .mdu_start(mdu_start), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .ex_mem_bubble(ex_mem_bubble), .mem_wb_bubble(mem_wb_bubble), .mdu_busy(mdu_busy),
    .mem_timeout(mem_timeout), .protocol_err(protocol_err), .stall_cnt(stall_cnt),
    .o_dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after the rising edge and hold for the cycle.
  task automatic cyc(input logic r, input logic lu, input logic bt,
                     input logic ms, input logic mq, input logic mr);
    @(posedge clk);
    #1;
    rst_n = r; load_use = lu; branch_taken = bt;
    mdu_start = ms; mem_req = mq; mem_ready = mr;
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference model + scoreboard ----------------
  // The model tracks the operation in flight: how many frozen MDU cycles
  // remain (-1 = no MDU op), whether a memory wait is open and how many
  // waiting cycles it has accumulated.
  int mdl_mdu_left  = -1;
  bit mdl_in_mem    = 1'b0;
  int mdl_mem_waits = 0;
  int mdl_stalls    = 0;
  bit mdl_to        = 1'b0;
  bit mdl_pe        = 1'b0;

  logic [8:0] exp_q[$];

  // Control vector order: pc, if_id, id_ex, ex_mem writes, flush, 3 bubbles, busy.
  always @(negedge clk) begin
    logic pcw, ifw, idw, exw, fl, idb, exb, mwb, busy;
    logic [8:0] exp_v, act_v;
    pcw = 1; ifw = 1; idw = 1; exw = 1; fl = 0; idb = 0; exb = 0; mwb = 0; busy = 0;

    // Registered outputs reflect the model before this cycle's update.
    chk("stall_cnt", int'(stall_cnt), mdl_stalls);
    chk("mem_timeout", int'(mem_timeout), int'(mdl_to));
    chk("protocol_err", int'(protocol_err), int'(mdl_pe));

    if (!rst_n) begin
      mdl_mdu_left = -1; mdl_in_mem = 0; mdl_mem_waits = 0;
      mdl_stalls = 0; mdl_to = 0; mdl_pe = 0;
    end else begin
      if (mdl_in_mem) begin
        if (mem_ready) begin
          mdl_in_mem = 0;
        end else begin
          pcw = 0; ifw = 0; idw = 0; exw = 0; mwb = 1;
          mdl_mem_waits++;
          if (mdl_mem_waits >= MEM_TIMEOUT) mdl_to = 1;
        end
      end else if (mdl_mdu_left >= 0) begin
        busy = 1;
        if (mdl_mdu_left > 0) begin
          pcw = 0; ifw = 0; idw = 0; exb = 1;
        end
        mdl_mdu_left--;
      end else if (mem_req && !mem_ready) begin
        pcw = 0; ifw = 0; idw = 0; exw = 0; mwb = 1;
        mdl_in_mem = 1; mdl_mem_waits = 0;
      end else if (mdu_start) begin
        pcw = 0; ifw = 0; idw = 0; exb = 1;
        mdl_mdu_left = MDU_LAT - 1;
        if (branch_taken) mdl_pe = 1;
      end else if (branch_taken) begin
        fl = 1; idb = 1;
      end else if (load_use) begin
        pcw = 0; ifw = 0; idb = 1;
      end
      if (!pcw && mdl_stalls < 65535) mdl_stalls++;
    end

    exp_q.push_back({pcw, ifw, idw, exw, fl, idb, exb, mwb, busy});
    exp_v = exp_q.pop_front();
    act_v = {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
             id_ex_bubble, ex_mem_bubble, mem_wb_bubble, mdu_busy};
    chk("ctl_vector", int'(act_v), int'(exp_v));
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    rst_n = 0; load_use = 0; branch_taken = 0; mdu_start = 0; mem_req = 0; mem_ready = 0;

    // Reset forces defaults regardless of inputs.
    cyc(0, 1, 1, 1, 1, 0);
    chk("rst_pc_write", pc_write, 1);
    chk("rst_if_id_flush", if_id_flush, 0);
    chk("rst_ex_mem_bubble", ex_mem_bubble, 0);
    chk("rst_mem_wb_bubble", mem_wb_bubble, 0);
    chk("rst_mdu_busy", mdu_busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("idle_pc_write", pc_write, 1);

    // Single load-use stall.
    cyc(1, 1, 0, 0, 0, 0);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_if_id_write", if_id_write, 0);
    chk("lu_id_ex_bubble", id_ex_bubble, 1);
    chk("lu_id_ex_write", id_ex_write, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("lu_after_pc_write", pc_write, 1);
    chk("lu_after_bubble", id_ex_bubble, 0);
    chk("lu_stall_cnt", stall_cnt, 1);

    // MDU op held for MDU_LAT cycles.
    cyc(1, 0, 0, 1, 0, 0);
    chk("mdu1_pc_write", pc_write, 0);
    chk("mdu1_ex_mem_bubble", ex_mem_bubble, 1);
    chk("mdu1_busy", mdu_busy, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 0, 0);
      chk("mdu_wait_pc_write", pc_write, 0);
      chk("mdu_wait_busy", mdu_busy, 1);
    end
    cyc(1, 1, 1, 1, 0, 0);  // release cycle: all requests ignored
    chk("mdu_rel_pc_write", pc_write, 1);
    chk("mdu_rel_busy", mdu_busy, 1);
    chk("mdu_rel_flush", if_id_flush, 0);
    chk("mdu_rel_id_ex_bubble", id_ex_bubble, 0);
    chk("mdu_rel_stall_cnt", stall_cnt, 5);
    cyc(1, 0, 0, 0, 0, 0);
    chk("mdu_done_busy", mdu_busy, 0);
    chk("mdu_done_perr", protocol_err, 0);

    // Branch beats load-use.
    cyc(1, 1, 1, 0, 0, 0);
    chk("br_pc_write", pc_write, 1);
    chk("br_if_id_write", if_id_write, 1);
    chk("br_flush", if_id_flush, 1);
    chk("br_id_ex_bubble", id_ex_bubble, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("br_stall_cnt", stall_cnt, 5);

    // MDU + branch together, then reset mid-MDU_WAIT.
    cyc(1, 0, 1, 1, 0, 0);
    chk("pe_flush", if_id_flush, 0);
    chk("pe_ex_mem_bubble", ex_mem_bubble, 1);
    chk("pe_pc_write", pc_write, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("pe_busy", mdu_busy, 1);
    chk("pe_flag", protocol_err, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pe_rst_busy", mdu_busy, 0);
    chk("pe_rst_pc_write", pc_write, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("pe_after_busy", mdu_busy, 0);
    chk("pe_after_flag", protocol_err, 0);
    chk("pe_after_stall_cnt", stall_cnt, 0);
    chk("pe_after_pc_write", pc_write, 1);

    // Memory wait: three frozen cycles, release on the fourth.
    cyc(1, 0, 0, 0, 1, 0);
    chk("mem_pc_write", pc_write, 0);
    chk("mem_ex_mem_write", ex_mem_write, 0);
    chk("mem_wb_bubble", mem_wb_bubble, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, 0, 1, 0);
      chk("mem_wait_ex_mem_write", ex_mem_write, 0);
    end
    cyc(1, 0, 0, 0, 1, 1);
    chk("mem_rel_pc_write", pc_write, 1);
    chk("mem_rel_ex_mem_write", ex_mem_write, 1);
    chk("mem_rel_wb_bubble", mem_wb_bubble, 0);
    chk("mem_rel_stall_cnt", stall_cnt, 3);
    chk("mem_rel_timeout", mem_timeout, 0);

    // Memory freeze pre-empts everything; MDU then branch honoured afterwards.
    cyc(1, 1, 1, 1, 1, 0);
    chk("pre_pc_write", pc_write, 0);
    chk("pre_ex_mem_bubble", ex_mem_bubble, 0);
    chk("pre_flush", if_id_flush, 0);
    chk("pre_wb_bubble", mem_wb_bubble, 1);
    chk("pre_id_ex_bubble", id_ex_bubble, 0);
    cyc(1, 1, 1, 1, 1, 1);
    chk("pre_rel_pc_write", pc_write, 1);
    chk("pre_rel_flush", if_id_flush, 0);
    chk("pre_rel_busy", mdu_busy, 0);
    chk("pre_rel_perr", protocol_err, 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk("post_mdu_pc_write", pc_write, 0);
    chk("post_mdu_bubble", ex_mem_bubble, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    chk("post_mdu_rel_flush", if_id_flush, 0);
    chk("post_mdu_rel_busy", mdu_busy, 1);
    cyc(1, 0, 1, 0, 0, 0);
    chk("post_br_flush", if_id_flush, 1);
    chk("post_br_pc_write", pc_write, 1);
    chk("post_br_perr", protocol_err, 0);
    chk("post_br_stall_cnt", stall_cnt, 8);

    // Timeout after the fifth MEM_WAIT cycle; freeze continues.
    cyc(1, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 0, 0, 1, 0);
      chk("to_flag", mem_timeout, (k >= 6) ? 1 : 0);
      chk("to_pc_write", pc_write, 0);
    end
    cyc(1, 0, 0, 0, 1, 1);
    chk("to_rel_flag", mem_timeout, 1);
    chk("to_rel_pc_write", pc_write, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("to_sticky", mem_timeout, 1);
    chk("to_stall_cnt", stall_cnt, 17);

    // Long memory stall saturates the stall counter.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("sat_start", stall_cnt, 0);
    for (int i = 0; i < 65540; i++) cyc(1, 0, 0, 0, 1, 0);
    chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    chk("sat_timeout", mem_timeout, 1);
    cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("sat_hold", stall_cnt, 16'hFFFF);
    chk("sat_pc_write", pc_write, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 4: total stall cycles for a multiply/divide in EX; legal range 2..16.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255: number of MEM_WAIT cycles after which mem_timeout sets; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 load_use  input  1  load-use hazard request from the hazard detector, level.
REQ-006 branch_taken  input  1  branch/jump resolved taken in EX, level.
REQ-007 mdu_start  input  1  multiply/divide instruction present in EX, level while it sits there.
REQ-008 mem_req  input  1  load/store present in MEM stage.
REQ-009 mem_ready  input  1  data memory completes the access in this cycle.
REQ-010 pc_write, if_id_write, id_ex_write, ex_mem_write  output  1 each  register write enables.
REQ-011 if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble  output  1 each  squash/bubble controls.
REQ-012 mdu_busy  output  1  high in MDU_WAIT.
REQ-013 mem_timeout  output  1  sticky memory-timeout flag.
REQ-014 protocol_err  output  1  sticky flag: mdu_start and branch_taken both high in RUN.
REQ-015 stall_cnt  output  16  count of cycles with pc_write=0, saturating.

Function
REQ-016 SHALL implement FSM with states RUN, MDU_WAIT, MEM_WAIT, plus 4-bit down-counter mcnt and 8-bit timer tcnt.
REQ-017 Defaults (unless overridden below): all write enables 1; all flush/bubble 0.
REQ-018 RUN, priority 1: mem_req=1 and mem_ready=0 -> all four write enables 0, mem_wb_bubble=1; next MEM_WAIT, tcnt<=1.
REQ-019 RUN, priority 2: mdu_start=1 -> pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1; mcnt<=MDU_LAT-1; next MDU_WAIT.
REQ-020 RUN, priority 3: branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; load_use ignored.
REQ-021 RUN, priority 4: load_use=1 -> pc_write=if_id_write=0, id_ex_bubble=1; single-cycle stall, state stays RUN.
REQ-022 RUN with mem_req=1 and mem_ready=1: no stall; lower priorities then evaluated normally.
REQ-023 RUN with mdu_start=1 and branch_taken=1 (not pre-empted by memory): mdu_start wins, branch ignored, protocol_err<=1.
REQ-024 MDU_WAIT, mcnt!=0: same freeze as REQ-019, mcnt decrements.
REQ-025 MDU_WAIT, mcnt==0: release cycle, defaults, mdu_start/branch_taken/load_use all ignored; next RUN.
REQ-026 Net MDU latency: mdu_start first seen at cycle T -> pc_write=0 for cycles T..T+MDU_LAT-1, 1 at T+MDU_LAT.
REQ-027 MEM_WAIT, mem_ready=0: freeze as REQ-018; tcnt increments, saturating at 255; when tcnt==MEM_TIMEOUT, mem_timeout<=1; state held (no abort).
REQ-028 MEM_WAIT, mem_ready=1: release cycle, defaults, other inputs ignored; next RUN.
REQ-029 mdu_busy=1 exactly when state==MDU_WAIT (including the release cycle).
REQ-030 stall_cnt increments every cycle pc_write=0; holds at 16'hFFFF.
REQ-031 Sticky flags clear only by reset.
REQ-032 All outputs except stall_cnt/flags are combinational from state, counters and current inputs; no added latency.

Reset
REQ-033 rst_n=0 at a clock edge -> state RUN, mcnt=0, tcnt=0, mem_timeout=0, protocol_err=0, stall_cnt=0.
REQ-034 While rst_n=0, outputs forced: all write enables 1, all flush/bubble 0, mdu_busy=0, regardless of inputs.
REQ-035 Reset asserted mid-MDU_WAIT or mid-MEM_WAIT abandons the operation; first cycle after release is RUN.

Verification
REQ-036 load_use=1 one cycle, no others -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle only; stall_cnt=1.
REQ-037 mdu_start held 4 cycles, MDU_LAT=4 -> pc_write=0 for 4 cycles, mdu_busy=1 cycles 2-4, release cycle 5; stall_cnt=4.
REQ-038 mem_req=1, mem_ready low 3 cycles then high -> all write enables 0 for 3 cycles, release on 4th; stall_cnt=3; mem_timeout=0.
REQ-039 MEM_TIMEOUT=5, mem_ready never high -> mem_timeout=1 after 5th MEM_WAIT cycle, stays 1, freeze persists until mem_ready.
REQ-040 mem_req stall, mdu_start, branch_taken, load_use all high in RUN -> memory freeze wins; mdu/branch honoured only after release.
REQ-041 mdu_start+branch_taken together -> MDU_WAIT entered, if_id_flush=0, protocol_err=1; rst_n=0 mid-MDU_WAIT -> RUN, flags 0.
